// File: rtl/button_conditioner.sv
// Button conditioner: synchronizes, debounces and edge-detects three pushbuttons,
// with auto-repeat on the step button and fixed pulse priority reset > run/halt > step.
module button_conditioner #(
    parameter int unsigned DB_CYCLES     = 50000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_step_raw,
    input  logic       btn_reset_raw,
    input  logic       btn_runhalt_raw,
    output logic       b_step,
    output logic       b_reset,
    output logic       b_runhalt,
    output logic [2:0] held
);

    localparam int unsigned N_CH    = 3;
    localparam int unsigned DB_W    = $clog2(DB_CYCLES);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [2:0]  IDLE_RAW = ACTIVE_LOW ? 3'b111 : 3'b000;

    // Channel order everywhere: bit 0 step, bit 1 reset, bit 2 run/halt.
    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      pressed;
    logic [2:0]      db;
    logic [2:0]      db_q;
    logic [DB_W-1:0] db_cnt [N_CH];
    logic [RPT_W-1:0] rpt_cnt;
    logic            rpt_phase;
    logic [RPT_W-1:0] rpt_target;
    logic            rpt_fire;
    logic [2:0]      rise;

    assign raw     = {btn_runhalt_raw, btn_reset_raw, btn_step_raw};
    assign pressed = ACTIVE_LOW ? ~sync2 : sync2;
    assign held    = db;

    // Two-flop synchronizer; resets to the released pin level so a held button looks new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= IDLE_RAW;
            sync2 <= IDLE_RAW;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-channel debounce: level follows only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db <= '0;
            for (int i = 0; i < N_CH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (pressed[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                    db[i]     <= pressed[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Repeat target: initial delay first, then the shorter steady period.
    always_comb begin
        rpt_target = rpt_phase ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY);
        rpt_fire   = db[0] && (rpt_cnt == rpt_target);
        rise       = db & ~db_q;
    end

    // Step auto-repeat counter; reloads on every fire so it never passes its target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
        end else if (!db[0]) begin
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt   <= RPT_W'(1);
            rpt_phase <= 1'b1;
        end else begin
            rpt_cnt   <= rpt_cnt + RPT_W'(1);
        end
    end

    // Registered one-cycle pulses with priority reset > run/halt > step; losers are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q      <= '0;
            b_reset   <= 1'b0;
            b_runhalt <= 1'b0;
            b_step    <= 1'b0;
        end else begin
            db_q      <= db;
            b_reset   <= rise[1];
            b_runhalt <= rise[2] & ~rise[1];
            b_step    <= (rise[0] | rpt_fire) & ~rise[1] & ~rise[2];
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized bench for button_conditioner against an edge-indexed reference model.
module tb_button_conditioner;

    localparam int DB     = 4;
    localparam int DELAY  = 20;
    localparam int PERIOD = 8;
    localparam int HIST   = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_step_raw = 1'b1;
    logic       btn_reset_raw = 1'b1;
    logic       btn_runhalt_raw = 1'b1;
    logic       b_step;
    logic       b_reset;
    logic       b_runhalt;
    logic [2:0] held;

    button_conditioner #(
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (DELAY),
        .REPEAT_PERIOD(PERIOD),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_step_raw   (btn_step_raw),
        .btn_reset_raw  (btn_reset_raw),
        .btn_runhalt_raw(btn_runhalt_raw),
        .b_step         (b_step),
        .b_reset        (b_reset),
        .b_runhalt      (b_runhalt),
        .held           (held)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: n counts edges since reset release; histories indexed by edge.
    int         n;
    int         p_edge;
    logic [2:0] press_m [HIST];
    logic [2:0] sync_m  [HIST];
    logic [2:0] db_m    [HIST];
    int         step_q[$];
    int         runhalt_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s edge %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    // Expected outputs after edge n, from the debounce/repeat/priority rules.
    task automatic model_edge(input logic [2:0] press, output logic [2:0] exp_held,
                              output logic [2:0] exp_pulse);
        logic [2:0] dprev, dprev2, dnew, rise;
        logic       rpt, all_diff;
        int         d;
        press_m[n % HIST] = press;
        sync_m[n % HIST]  = (n == 0) ? 3'b000 : press_m[(n - 1) % HIST];
        dprev  = (n >= 1) ? db_m[(n - 1) % HIST] : 3'b000;
        dprev2 = (n >= 2) ? db_m[(n - 2) % HIST] : 3'b000;
        dnew   = dprev;
        if (n >= DB) begin
            for (int ch = 0; ch < 3; ch++) begin
                all_diff = 1'b1;
                for (int k = 1; k <= DB; k++)
                    if (sync_m[(n - k) % HIST][ch] == dprev[ch]) all_diff = 1'b0;
                if (all_diff) dnew[ch] = ~dprev[ch];
            end
        end
        db_m[n % HIST] = dnew;
        rise = dprev & ~dprev2;
        if (!dprev[0]) p_edge = -1;
        else if (rise[0]) p_edge = n;
        d   = n - p_edge;
        rpt = dprev[0] && (p_edge >= 0) && (d >= DELAY) && (((d - DELAY) % PERIOD) == 0);
        exp_held     = dnew;
        exp_pulse[1] = rise[1];
        exp_pulse[2] = rise[2] & ~rise[1];
        exp_pulse[0] = (rise[0] | rpt) & ~rise[1] & ~rise[2];
    endtask

    // One clock: drive pins (active low), advance model, compare at the falling edge.
    task automatic run_cycle(input logic [2:0] press);
        logic [2:0] eh, ep;
        btn_step_raw    = ~press[0];
        btn_reset_raw   = ~press[1];
        btn_runhalt_raw = ~press[2];
        @(posedge clk);
        model_edge(press, eh, ep);
        @(negedge clk);
        check("held", 32'(held), 32'(eh));
        check("b_step", 32'(b_step), 32'(ep[0]));
        check("b_reset", 32'(b_reset), 32'(ep[1]));
        check("b_runhalt", 32'(b_runhalt), 32'(ep[2]));
        check("onehot", 32'(int'(b_step) + int'(b_reset) + int'(b_runhalt) <= 1), 32'd1);
        if (b_step) step_q.push_back(n);
        if (b_runhalt) runhalt_cnt++;
        n++;
    endtask

    // Assert reset mid-cycle (pins unchanged), confirm outputs clear at once, release on a negedge.
    task automatic do_reset(input int cycles);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_held", 32'(held), 32'd0);
        check("rst_pulses", 32'({b_runhalt, b_reset, b_step}), 32'd0);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        n      = 0;
        p_edge = -1;
    endtask

    task automatic run_hold(input logic [2:0] press, input int cycles);
        for (int i = 0; i < cycles; i++) run_cycle(press);
    endtask

    initial begin
        int         exp_edges[6];
        logic [2:0] cur;
        int         len;
        exp_edges = '{6, 26, 34, 42, 50, 58};
        n = 0;
        p_edge = -1;
        runhalt_cnt = 0;

        @(negedge clk);
        do_reset(2);

        // Run/halt press of 10 cycles: one pulse, none on release.
        run_hold(3'b100, 10);
        run_hold(3'b000, 20);
        check("runhalt_count", 32'(runhalt_cnt), 32'd1);

        // Short glitch on step leaves everything idle.
        do_reset(1);
        run_hold(3'b001, 3);
        run_hold(3'b000, 15);

        // Long step press with auto-repeat.
        do_reset(1);
        step_q.delete();
        run_hold(3'b001, 60);
        run_hold(3'b000, 15);
        check("repeat_count", 32'(step_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < step_q.size(); i++)
            check("repeat_edge", 32'(step_q[i]), 32'(exp_edges[i]));

        // Reset and step together: reset wins, step only via repeat.
        do_reset(1);
        step_q.delete();
        run_hold(3'b011, 30);
        check("simul_first_step", 32'(step_q.size() > 0 ? step_q[0] : -1), 32'd26);
        run_hold(3'b000, 12);

        // Reset mid-debounce with the button still held.
        do_reset(1);
        step_q.delete();
        run_hold(3'b001, 3);
        do_reset(2);
        run_hold(3'b001, 12);
        check("held_thru_reset", 32'(step_q.size() > 0 ? step_q[0] : -1), 32'd6);
        run_hold(3'b000, 10);

        // Random presses of varying lengths, with occasional resets.
        for (int seg = 0; seg < 250; seg++) begin
            cur = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) cur = 3'b000;
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(30, 70))
                                               : int'($urandom_range(1, 12));
            if ($urandom_range(0, 29) == 0) do_reset(int'($urandom_range(1, 3)));
            run_hold(cur, len);
        end
        run_hold(3'b000, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 50000: consecutive clk cycles a synchronized level must hold before the debounced level follows it; legal range is 2 or more.
REQ-002 Parameter REPEAT_DELAY, default 25000000: cycles from the first step pulse to the first auto-repeat pulse; legal range is 2 or more.
REQ-003 Parameter REPEAT_PERIOD, default 5000000: cycles between later auto-repeat pulses; legal range is 2 or more.
REQ-004 Parameter ACTIVE_LOW, default 1: when 1, a raw pin reads 0 while its button is pressed; when 0, it reads 1 while pressed.
REQ-005 clk  in  1  system clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 btn_step_raw  in  1  step pushbutton pin, asynchronous to clk.
REQ-008 btn_reset_raw  in  1  reset pushbutton pin, asynchronous to clk.
REQ-009 btn_runhalt_raw  in  1  run/halt pushbutton pin, asynchronous to clk.
REQ-010 b_step  out  1  one-cycle pulse requesting a single step (feeds the CPU control block).
REQ-011 b_reset  out  1  one-cycle pulse requesting a reset-step.
REQ-012 b_runhalt  out  1  one-cycle pulse requesting a run/halt toggle.
REQ-013 held  out  3  debounced pressed levels as {runhalt, reset, step}; 1 means pressed.

Function
REQ-014 Each raw input SHALL pass through a 2-flop synchronizer; when ACTIVE_LOW=1 the synchronized value is inverted, so internally 1 always means pressed.
REQ-015 Each channel SHALL keep an independent debounced level and a debounce counter; any cycle in which the synchronized level equals the debounced level SHALL clear the counter.
REQ-016 Debounce latency: if a raw change is first sampled at edge 0 and stays stable, the debounced level and held SHALL update at edge 1+DB_CYCLES.
REQ-017 A raw change lasting fewer than DB_CYCLES cycles SHALL leave the debounced level and held unchanged.
REQ-018 A debounced 0->1 transition SHALL produce that channel's pulse, high for exactly one cycle, registered at the next edge (edge 2+DB_CYCLES).
REQ-019 A debounced 1->0 transition (button release) SHALL produce no pulse.
REQ-020 Auto-repeat applies to the step channel only.
REQ-021 While step's debounced level is high, the repeat counter runs; repeat pulse k (k>=1) SHALL occur at first-pulse edge + REPEAT_DELAY + (k-1)*REPEAT_PERIOD.
REQ-022 A repeat pulse SHALL fire only if step's debounced level was high in the cycle before that edge; a debounced fall clears the repeat counter.
REQ-023 At most one of b_step, b_reset, b_runhalt SHALL be high in any cycle.
REQ-024 If several pulses are due in the same cycle, priority is b_reset > b_runhalt > b_step; lower-priority pulses are dropped, not queued.
REQ-025 The reset and run/halt channels SHALL never auto-repeat, however long they are held.
REQ-026 Counter widths are sized from the parameters; counters SHALL saturate or clear and never wrap to produce a spurious pulse.

Reset
REQ-027 While rst_n is low, all synchronizer flops SHALL hold the released value, all debounced levels are 0, all counters are 0, and b_step, b_reset, b_runhalt and held are all 0, taking effect immediately (asynchronously).
REQ-028 A button held through reset deassertion SHALL be treated as a new press, producing its pulse with the full REQ-016/REQ-018 latency counted from the first edge after rst_n rises.
REQ-029 Asserting rst_n mid-debounce or mid-repeat SHALL abort that activity with no pulse.

Verification (DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, ACTIVE_LOW=1)
REQ-030 btn_runhalt_raw driven low from edge 0 for 10 cycles -> held[2] rises at edge 5; b_runhalt is high for one cycle after edge 6; no pulse on release.
REQ-031 btn_step_raw driven low for 3 cycles, then high -> held stays 3'b000; no pulses.
REQ-032 btn_step_raw low on edges 0..59, high from edge 60 -> b_step pulses after edges 6, 26, 34, 42, 50 and 58 only; held[0] falls at edge 65.
REQ-033 btn_reset_raw and btn_step_raw driven low on the same edge and held -> only b_reset pulses, at edge 6; held becomes 3'b011; no b_step pulse until the step auto-repeat pulse at edge 26.
REQ-034 rst_n pulsed low at edge 3 of a step press, with the button still held -> outputs go 0 immediately; after rst_n rises, b_step pulses at edge 6 counted from the first edge after release.
